// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and helpers for branch_predictor
// BTB entry layout, PC index/tag split, saturating counter arithmetic and counter reset values.
package bp_pkg;

  localparam int CTR_MAX_W = 4;
  localparam int TAG_MAX_W = 30;

  typedef struct packed {
    logic                 valid;
    logic                 is_jump;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Upper tag bits beyond the configured width are always zero, so full-width compare is safe
  function automatic logic [TAG_MAX_W-1:0] pc_tag(input logic [31:0] pc, input int idx_w);
    return TAG_MAX_W'(pc >> (idx_w + 2));
  endfunction

  function automatic logic [CTR_MAX_W-1:0] sat_inc(input logic [CTR_MAX_W-1:0] c, input int bits);
    logic [CTR_MAX_W-1:0] max_v;
    max_v = CTR_MAX_W'((1 << bits) - 1);
    return (c == max_v) ? c : c + 1'b1;
  endfunction

  function automatic logic [CTR_MAX_W-1:0] sat_dec(input logic [CTR_MAX_W-1:0] c, input int bits);
    logic [CTR_MAX_W-1:0] min_v;
    min_v = CTR_MAX_W'(bits - bits);
    return (c == min_v) ? c : c - 1'b1;
  endfunction

  localparam logic [CTR_MAX_W-1:0] CTR_RESET_BTB = '0;

  function automatic logic [CTR_MAX_W-1:0] ctr_weak_taken(input int bits);
    return CTR_MAX_W'(1 << (bits - 1));
  endfunction

  function automatic logic [CTR_MAX_W-1:0] ctr_weak_not_taken(input int bits);
    return CTR_MAX_W'((1 << (bits - 1)) - 1);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup and EX resolution signals of branch_predictor
// master = core pipeline, slave = predictor.
interface branch_predictor_if #(
  parameter int GHR_BITS = 6
);
  logic [31:0]         pcF;
  logic                predict_takenF;
  logic [31:0]         predict_targetF;
  logic [GHR_BITS-1:0] predict_ghrF;
  logic                update_en;
  logic [31:0]         update_pc;
  logic                update_is_branch;
  logic                update_taken;
  logic [31:0]         update_target;
  logic [GHR_BITS-1:0] update_ghr;
  logic                predictedE;
  logic [31:0]         predicted_targetE;
  logic                mispredictE;
  logic [31:0]         redirect_pcE;

  modport master (
    output pcF, update_en, update_pc, update_is_branch, update_taken, update_target,
           update_ghr, predictedE, predicted_targetE,
    input  predict_takenF, predict_targetF, predict_ghrF, mispredictE, redirect_pcE
  );

  modport slave (
    input  pcF, update_en, update_pc, update_is_branch, update_taken, update_target,
           update_ghr, predictedE, predicted_targetE,
    output predict_takenF, predict_targetF, predict_ghrF, mispredictE, redirect_pcE
  );
endinterface

// File: rtl/bp_counter_table.sv
// rtl/bp_counter_table.sv - array of saturating direction counters
// One combinational read port, one synchronous update port (increment/decrement/set weakly taken).
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int                   DEPTH     = 64,
  parameter int                   CTR_BITS  = 2,
  parameter logic [CTR_MAX_W-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [CTR_BITS-1:0]      rd_ctr,
  input  logic                     upd_en,
  input  logic [$clog2(DEPTH)-1:0] upd_idx,
  input  logic                     upd_set,
  input  logic                     upd_taken
);
  localparam logic [CTR_MAX_W-1:0] WEAK_T = ctr_weak_taken(CTR_BITS);

  logic [CTR_BITS-1:0] ctr_q [DEPTH];
  logic [CTR_BITS-1:0] ctr_d;

  assign rd_ctr = ctr_q[rd_idx];

  always_comb begin
    if (upd_set) begin
      ctr_d = CTR_BITS'(WEAK_T);
    end else if (upd_taken) begin
      ctr_d = CTR_BITS'(sat_inc(CTR_MAX_W'(ctr_q[upd_idx]), CTR_BITS));
    end else begin
      ctr_d = CTR_BITS'(sat_dec(CTR_MAX_W'(ctr_q[upd_idx]), CTR_BITS));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_BITS'(RESET_VAL);
    end else if (upd_en) begin
      ctr_q[upd_idx] <= ctr_d;
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB predictor with EX-stage update and perf counters
// BP_GSHARE_EN moves the direction counters into a GHR-hashed pattern history table.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 6
) (
  input  logic              clk,
  input  logic              rst,
  branch_predictor_if.slave bp,
  output logic [31:0]       branch_cnt,
  output logic [31:0]       mispred_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);

  btb_entry_t          btb_q [ENTRIES];
  btb_entry_t          f_ent;
  logic [IDX_W-1:0]    f_idx, u_idx, f_cidx, u_cidx;
  logic                f_hit, u_hit, pred_taken, mispredict;
  logic [CTR_BITS-1:0] f_ctr;
  logic                ctr_upd_en, ctr_upd_set;
  logic [31:0]         branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    f_idx = IDX_W'(pc_index(bp.pcF, IDX_W));
    u_idx = IDX_W'(pc_index(bp.update_pc, IDX_W));
    f_ent = btb_q[f_idx];
    f_hit = f_ent.valid && (f_ent.tag == pc_tag(bp.pcF, IDX_W));
    u_hit = btb_q[u_idx].valid && (btb_q[u_idx].tag == pc_tag(bp.update_pc, IDX_W));
  end

`ifdef BP_GSHARE_EN
  localparam logic [CTR_MAX_W-1:0] CTR_RST = ctr_weak_not_taken(CTR_BITS);

  logic [GHR_BITS-1:0] ghr_q, ghr_d;

  // History is only advanced by resolved conditional branches, never speculatively
  always_comb begin
    ghr_d = ghr_q;
    if (bp.update_en && bp.update_is_branch) ghr_d = GHR_BITS'({ghr_q, bp.update_taken});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end

  assign f_cidx          = f_idx ^ IDX_W'(ghr_q);
  assign u_cidx          = u_idx ^ IDX_W'(bp.update_ghr);
  assign ctr_upd_en      = bp.update_en & bp.update_is_branch;
  assign ctr_upd_set     = 1'b0;
  assign bp.predict_ghrF = ghr_q;
`else
  localparam logic [CTR_MAX_W-1:0] CTR_RST = CTR_RESET_BTB;

  assign f_cidx          = f_idx;
  assign u_cidx          = u_idx;
  // In-entry counters: train on branch hits, seed weakly taken on allocation
  assign ctr_upd_en      = bp.update_en & ((u_hit & bp.update_is_branch) | (~u_hit & bp.update_taken));
  assign ctr_upd_set     = ~u_hit;
  assign bp.predict_ghrF = '0;
`endif

  bp_counter_table #(
    .DEPTH    (ENTRIES),
    .CTR_BITS (CTR_BITS),
    .RESET_VAL(CTR_RST)
  ) u_ctr_table (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (f_cidx),
    .rd_ctr   (f_ctr),
    .upd_en   (ctr_upd_en),
    .upd_idx  (u_cidx),
    .upd_set  (ctr_upd_set),
    .upd_taken(bp.update_taken)
  );

  always_comb begin
    pred_taken         = f_hit & (f_ent.is_jump | f_ctr[CTR_BITS-1]);
    bp.predict_takenF  = pred_taken;
    bp.predict_targetF = pred_taken ? f_ent.target : bp.pcF + 32'd4;
    mispredict         = bp.update_en &
                         ((bp.predictedE != bp.update_taken) |
                          (bp.update_taken & (bp.predicted_targetE != bp.update_target)));
    bp.mispredictE     = mispredict;
    bp.redirect_pcE    = bp.update_taken ? bp.update_target : bp.update_pc + 32'd4;
  end

  // Tag/target/is_jump are deliberately left out of reset; valid alone gates them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) btb_q[i].valid <= 1'b0;
    end else if (bp.update_en && (u_hit || bp.update_taken)) begin
      btb_q[u_idx] <= '{valid:   1'b1,
                        is_jump: ~bp.update_is_branch,
                        tag:     pc_tag(bp.update_pc, IDX_W),
                        target:  bp.update_target};
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (bp.update_en && (branch_cnt_q != 32'hFFFF_FFFF)) branch_cnt_d = branch_cnt_q + 32'd1;
    if (mispredict && (mispred_cnt_q != 32'hFFFF_FFFF)) mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
endmodule
